// File: rtl/sr_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_sequencer
// Brief    : Round-robin set/clear pulse sequencer and auto-clear for an SR latch bank.
// Revision : 1.0 - initial release
// ============================================================================
module sr_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int PULSE = 2
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_op,
    input  logic [NREQ*WIDTH-1:0]     req_mask,
    input  logic                      clr_all,
    output logic [NREQ-1:0]           req_ack,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic [WIDTH-1:0]          latch_s,
    output logic [WIDTH-1:0]          latch_r,
    output logic                      latch_en,
    output logic                      latch_reset
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PULSE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_RELEASE = 2'd2,
        S_CLEAR   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              clr_pend_q, clr_pend_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic              op_q, op_d;
    logic [NREQ-1:0]   req_ack_q, req_ack_d;
    logic [PW-1:0]     grant_id_q, grant_id_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  latch_s_q, latch_s_d;
    logic [WIDTH-1:0]  latch_r_q, latch_r_d;
    logic              latch_en_q, latch_en_d;
    logic              latch_reset_q, latch_reset_d;

    logic              found;
    logic [PW-1:0]     gsel;
    logic [WIDTH-1:0]  sel_mask;

    // Round-robin search starting at the pointer, wrapping at NREQ
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        found = 1'b0;
        gsel  = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = PW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
    end

    assign sel_mask = req_mask[gsel*WIDTH +: WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        clr_pend_d = clr_pend_q | clr_all;
        mask_d     = mask_q;
        op_d       = op_q;
        grant_id_d = grant_id_q;
        req_ack_d  = '0;

        case (state_q)
            S_IDLE: begin
                clr_pend_d = 1'b0;
                if (clr_pend_q || clr_all) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (found) begin
                    grant_id_d = gsel;
                    ptr_d      = (gsel == PW'(NREQ - 1)) ? '0 : gsel + 1'b1;
                    mask_d     = sel_mask;
                    op_d       = req_op[gsel];
                    // An empty mask has nothing to pulse: acknowledge and stay idle
                    if (sel_mask == '0) begin
                        req_ack_d[gsel] = 1'b1;
                    end else begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d               = S_RELEASE;
                    cnt_d                 = '0;
                    req_ack_d[grant_id_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pins are registered from the next state so they align with it
        busy_d        = (state_d != S_IDLE);
        latch_en_d    = (state_d == S_DRIVE);
        latch_reset_d = (state_d == S_CLEAR);
        latch_s_d     = (state_d == S_DRIVE &&  op_d) ? mask_d : '0;
        latch_r_d     = (state_d == S_DRIVE && !op_d) ? mask_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q       <= S_CLEAR;
            cnt_q         <= '0;
            ptr_q         <= '0;
            clr_pend_q    <= 1'b0;
            mask_q        <= '0;
            op_q          <= 1'b0;
            req_ack_q     <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b1;
            latch_s_q     <= '0;
            latch_r_q     <= '0;
            latch_en_q    <= 1'b0;
            latch_reset_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            clr_pend_q    <= clr_pend_d;
            mask_q        <= mask_d;
            op_q          <= op_d;
            req_ack_q     <= req_ack_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            latch_s_q     <= latch_s_d;
            latch_r_q     <= latch_r_d;
            latch_en_q    <= latch_en_d;
            latch_reset_q <= latch_reset_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign latch_s     = latch_s_q;
    assign latch_r     = latch_r_q;
    assign latch_en    = latch_en_q;
    assign latch_reset = latch_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_bank_sequencer
// Brief    : Directed and randomized bench for sr_bank_sequencer with a schedule-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_bank_sequencer;

    localparam int W = 8;
    localparam int N = 4;
    localparam int P = 2;

    logic           clk;
    logic           resetN;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_op;
    logic [N*W-1:0] req_mask;
    logic           clr_all;
    logic [N-1:0]   req_ack;
    logic [1:0]     grant_id;
    logic           busy;
    logic [W-1:0]   latch_s;
    logic [W-1:0]   latch_r;
    logic           latch_en;
    logic           latch_reset;

    sr_bank_sequencer #(.WIDTH(W), .NREQ(N), .PULSE(P)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_mask    (req_mask),
        .clr_all     (clr_all),
        .req_ack     (req_ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .latch_s     (latch_s),
        .latch_r     (latch_r),
        .latch_en    (latch_en),
        .latch_reset (latch_reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected pin vector for one cycle
    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic         en;
        logic         rs;
        logic         bsy;
        logic [N-1:0] ack;
    } vec_t;

    function automatic vec_t mk(input logic [W-1:0] s, input logic [W-1:0] r, input logic en,
                                input logic rs, input logic bsy, input logic [N-1:0] ack);
        vec_t v;
        v.s = s; v.r = r; v.en = en; v.rs = rs; v.bsy = bsy; v.ack = ack;
        return v;
    endfunction

    // Model: when a transaction starts, the whole future pin schedule is queued;
    // the block is free to decide again only once that schedule has drained.
    vec_t         m_cur;
    vec_t         m_q[$];
    int           m_ptr;
    bit           m_pend;
    int           m_gid;
    bit           m_valid = 0;
    int           m_found;
    int           m_c;
    logic [W-1:0] m_msk;
    vec_t         m_v;

    task automatic push_tail(input logic [N-1:0] ack);
        m_q.push_back(mk('0, '0, 1'b0, 1'b0, 1'b1, ack));
        m_q.push_back(mk('0, '0, 1'b0, 1'b0, 1'b0, '0));
    endtask

    always @(posedge clk) begin
        if (!resetN) begin
            m_valid = 1;
            m_q.delete();
            m_ptr  = 0;
            m_pend = 0;
            m_gid  = 0;
            m_cur  = mk('0, '0, 1'b0, 1'b1, 1'b1, '0);
            for (int k = 0; k < P - 1; k++) m_q.push_back(m_cur);
            push_tail('0);
        end else if (m_valid) begin
            if (m_q.size() > 0) begin
                if (clr_all) m_pend = 1;
                m_cur = m_q.pop_front();
            end else if (m_pend || clr_all) begin
                m_pend = 0;
                m_cur  = mk('0, '0, 1'b0, 1'b1, 1'b1, '0);
                for (int k = 0; k < P - 1; k++) m_q.push_back(m_cur);
                push_tail('0);
            end else begin
                m_found = -1;
                for (int k = 0; k < N; k++) begin
                    m_c = (m_ptr + k) % N;
                    if (m_found < 0 && req_valid[m_c]) m_found = m_c;
                end
                if (m_found >= 0) begin
                    m_gid = m_found;
                    m_ptr = (m_found + 1) % N;
                    m_msk = req_mask[m_found*W +: W];
                    if (m_msk == '0) begin
                        m_cur = mk('0, '0, 1'b0, 1'b0, 1'b0, N'(1) << m_found);
                    end else begin
                        if (req_op[m_found]) m_v = mk(m_msk, '0, 1'b1, 1'b0, 1'b1, '0);
                        else                 m_v = mk('0, m_msk, 1'b1, 1'b0, 1'b1, '0);
                        m_cur = m_v;
                        for (int k = 0; k < P - 1; k++) m_q.push_back(m_v);
                        push_tail(N'(1) << m_found);
                    end
                end else begin
                    m_cur = mk('0, '0, 1'b0, 1'b0, 1'b0, '0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("latch_s",     32'(latch_s),     32'(m_cur.s));
            chk("latch_r",     32'(latch_r),     32'(m_cur.r));
            chk("latch_en",    32'(latch_en),    32'(m_cur.en));
            chk("latch_reset", 32'(latch_reset), 32'(m_cur.rs));
            chk("busy",        32'(busy),        32'(m_cur.bsy));
            chk("req_ack",     32'(req_ack),     32'(m_cur.ack));
            if ((m_cur.bsy && !m_cur.rs) || m_cur.ack != '0)
                chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("s_r_overlap",     32'((latch_s != '0) && (latch_r != '0)), 32'd0);
            chk("reset_overlap",   32'(latch_reset && ((latch_s | latch_r) != '0)), 32'd0);
        end
    end

    // Edge-triggered latch bank fed from the DUT pins
    logic [W-1:0] bank_q, s_prev, r_prev;
    always @(posedge clk) begin
        if (latch_reset === 1'b1) bank_q <= '0;
        else if (latch_en === 1'b1) bank_q <= (bank_q | (latch_s & ~s_prev)) & ~(latch_r & ~r_prev);
        s_prev <= latch_s;
        r_prev <= latch_r;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic op, input logic [W-1:0] m);
        req_valid[i]       = 1'b1;
        req_op[i]          = op;
        req_mask[i*W +: W] = m;
    endtask

    task automatic do_req(input int i, input logic op, input logic [W-1:0] m);
        logic got;
        got = 1'b0;
        set_req(i, op, m);
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            if (req_ack[i]) got = 1'b1;
        end
        req_valid[i] = 1'b0;
        chk("ack_wait", 32'(got), 32'd1);
        step();
    endtask

    int ack_idx[4];
    int ack_cyc[4];
    int n_acks;
    int cyc;
    int rst_hold;
    int ack1_cnt;

    initial begin
        resetN    = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_mask  = '0;
        clr_all   = 1'b0;

        // Reset held three cycles, then the automatic clear
        step(); step(); step();
        chk("rst_latch_reset", 32'(latch_reset), 32'd1);
        chk("rst_busy",        32'(busy),        32'd1);
        chk("rst_ack",         32'(req_ack),     32'd0);
        resetN = 1'b1;
        step();
        chk("rst_clear2", 32'(latch_reset), 32'd1);
        step();
        chk("rst_release", 32'(latch_reset), 32'd0);
        chk("rst_release_busy", 32'(busy), 32'd1);
        step();
        chk("rst_idle_busy", 32'(busy), 32'd0);
        chk("rst_bank", 32'(bank_q), 32'h00);

        // Single set of 0xA5 from requester 1
        set_req(1, 1'b1, 8'hA5);
        step();
        chk("set_s1",  32'(latch_s),  32'hA5);
        chk("set_en1", 32'(latch_en), 32'd1);
        step();
        chk("set_s2",  32'(latch_s),  32'hA5);
        step();
        chk("set_ack", 32'(req_ack), 32'b0010);
        chk("set_rel", 32'(latch_en), 32'd0);
        req_valid[1] = 1'b0;
        step();
        chk("set_idle", 32'(busy), 32'd0);
        chk("set_bank", 32'(bank_q), 32'hA5);

        do_req(1, 1'b0, 8'h05);
        chk("clr_bank", 32'(bank_q), 32'hA0);

        // Zero mask: acknowledged next cycle, no bank activity
        set_req(3, 1'b1, 8'h00);
        step();
        chk("zero_ack", 32'(req_ack), 32'b1000);
        chk("zero_en",  32'(latch_en), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);
        req_valid[3] = 1'b0;
        step();

        // Contention among requesters 0, 1, 3
        set_req(0, 1'b1, 8'h11);
        set_req(1, 1'b0, 8'h22);
        set_req(3, 1'b1, 8'h33);
        n_acks = 0;
        for (cyc = 0; cyc < 40 && n_acks < 4; cyc++) begin
            step();
            if (req_ack != '0) begin
                for (int i = 0; i < N; i++) if (req_ack[i]) ack_idx[n_acks] = i;
                ack_cyc[n_acks] = cyc;
                n_acks++;
            end
        end
        req_valid = '0;
        chk("cont_acks", 32'(n_acks), 32'd4);
        chk("cont_o0", 32'(ack_idx[0]), 32'd0);
        chk("cont_o1", 32'(ack_idx[1]), 32'd1);
        chk("cont_o2", 32'(ack_idx[2]), 32'd3);
        chk("cont_o3", 32'(ack_idx[3]), 32'd0);
        for (int k = 1; k < 4; k++) chk("cont_gap", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd4);
        step();

        // clr_all during DRIVE of requester 2
        set_req(2, 1'b1, 8'hFF);
        step();
        clr_all = 1'b1;
        step();
        clr_all = 1'b0;
        step();
        chk("cd_ack", 32'(req_ack), 32'b0100);
        req_valid[2] = 1'b0;
        step();
        chk("cd_idle", 32'(busy), 32'd0);
        step();
        chk("cd_clr1", 32'(latch_reset), 32'd1);
        step();
        chk("cd_clr2", 32'(latch_reset), 32'd1);
        step();
        chk("cd_rel", 32'(latch_reset), 32'd0);
        chk("cd_bank", 32'(bank_q), 32'h00);
        step();

        // Reset during the second DRIVE cycle aborts, then re-serves
        set_req(1, 1'b1, 8'h3C);
        step();
        step();
        chk("rd_s", 32'(latch_s), 32'h3C);
        resetN = 1'b0;
        step();
        chk("rd_s0",   32'(latch_s),     32'h00);
        chk("rd_rst",  32'(latch_reset), 32'd1);
        chk("rd_ack0", 32'(req_ack),     32'd0);
        resetN   = 1'b1;
        ack1_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (req_ack[1]) begin
                ack1_cnt++;
                req_valid[1] = 1'b0;
            end
        end
        chk("rd_reack", 32'(ack1_cnt), 32'd1);

        // Randomized traffic
        rst_hold = 0;
        for (int t = 0; t < 3000; t++) begin
            step();
            clr_all = ($urandom_range(0, 39) == 0);
            if (rst_hold > 0) begin
                resetN = 1'b0;
                rst_hold--;
            end else begin
                resetN = 1'b1;
                if ($urandom_range(0, 399) == 0) rst_hold = $urandom_range(1, 3);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ack[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                end
            end
        end

        req_valid = '0;
        clr_all   = 1'b0;
        resetN    = 1'b1;
        for (int t = 0; t < 10; t++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
